// File: rtl/axi_multicut_cfg_if.sv
// AXI4 bundle with all five channels; "in" is the slave-facing view, "out" the master-facing view.
interface AXI_BUS #(
    parameter int AXI_ADDR_WIDTH = -1,
    parameter int AXI_DATA_WIDTH = -1,
    parameter int AXI_ID_WIDTH   = -1,
    parameter int AXI_USER_WIDTH = -1
);
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport in (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport out (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/axi_multicut_cfg.sv
// Configurable chain of fully registered two-slot cuts on every AXI channel,
// with per-channel bypass and a busy flag covering all buffered beats.
module axi_multicut_cfg_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             busy_o
);
    logic             a_full_reg, a_full_next;
    logic             b_full_reg, b_full_next;
    logic [WIDTH-1:0] a_data_reg, a_data_next;
    logic [WIDTH-1:0] b_data_reg, b_data_next;
    logic             drain;
    logic             accept;

    assign drain  = a_full_reg & ready_i;
    assign accept = valid_i & ~b_full_reg;

    always_comb begin
        a_full_next = a_full_reg;
        b_full_next = b_full_reg;
        a_data_next = a_data_reg;
        b_data_next = b_data_reg;
        if (b_full_reg) begin
            // spill slot refills the output slot; upstream is stalled this cycle
            if (drain) begin
                a_data_next = b_data_reg;
                b_full_next = 1'b0;
            end
        end else if (accept) begin
            if (!a_full_reg || drain) begin
                a_full_next = 1'b1;
                a_data_next = data_i;
            end else begin
                b_full_next = 1'b1;
                b_data_next = data_i;
            end
        end else if (drain) begin
            a_full_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_full_reg <= 1'b0;
            b_full_reg <= 1'b0;
            a_data_reg <= '0;
            b_data_reg <= '0;
        end else begin
            a_full_reg <= a_full_next;
            b_full_reg <= b_full_next;
            a_data_reg <= a_data_next;
            b_data_reg <= b_data_next;
        end
    end

    assign valid_o = a_full_reg;
    assign data_o  = a_data_reg;
    assign ready_o = ~b_full_reg;
    assign busy_o  = a_full_reg | b_full_reg;
endmodule

module axi_multicut_cfg_chan #(
    parameter int WIDTH    = 1,
    parameter int NUM_CUTS = 1,
    parameter bit BYPASS   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             busy_o
);
    if (BYPASS || NUM_CUTS == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign valid_o = valid_i;
        assign data_o  = data_i;
        assign ready_o = ready_i;
        assign busy_o  = 1'b0;
    end else begin : g_cut
        logic [NUM_CUTS:0]   valid_c;
        logic [NUM_CUTS:0]   ready_c;
        logic [WIDTH-1:0]    data_c [NUM_CUTS+1];
        logic [NUM_CUTS-1:0] busy_c;

        assign valid_c[0]        = valid_i;
        assign data_c[0]         = data_i;
        assign ready_c[NUM_CUTS] = ready_i;

        for (genvar gi = 0; gi < NUM_CUTS; gi++) begin : g_stage
            axi_multicut_cfg_stage #(.WIDTH(WIDTH)) u_stage (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .valid_i (valid_c[gi]),
                .ready_o (ready_c[gi]),
                .data_i  (data_c[gi]),
                .valid_o (valid_c[gi+1]),
                .ready_i (ready_c[gi+1]),
                .data_o  (data_c[gi+1]),
                .busy_o  (busy_c[gi])
            );
        end

        assign valid_o = valid_c[NUM_CUTS];
        assign data_o  = data_c[NUM_CUTS];
        assign ready_o = ready_c[0];
        assign busy_o  = |busy_c;
    end
endmodule

module axi_multicut_cfg #(
    parameter int         ADDR_WIDTH  = -1,
    parameter int         DATA_WIDTH  = -1,
    parameter int         ID_WIDTH    = -1,
    parameter int         USER_WIDTH  = -1,
    parameter int         NUM_CUTS    = 1,
    parameter logic [4:0] BYPASS_MASK = 5'b00000
) (
    input  logic clk_i,
    input  logic rst_i,
    AXI_BUS.in   in,
    AXI_BUS.out  out,
    output logic busy_o
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    // len + size + burst + lock + cache + prot + qos + region = 29 bits
    localparam int AX_WIDTH   = ID_WIDTH + ADDR_WIDTH + 29 + USER_WIDTH;
    localparam int W_WIDTH    = DATA_WIDTH + STRB_WIDTH + 1 + USER_WIDTH;
    localparam int B_WIDTH    = ID_WIDTH + 2 + USER_WIDTH;
    localparam int R_WIDTH    = ID_WIDTH + DATA_WIDTH + 3 + USER_WIDTH;

`ifndef SYNTHESIS
    if (ADDR_WIDTH < 1 || ID_WIDTH < 1 || USER_WIDTH < 1) begin : g_bad_width
        $error("axi_multicut_cfg: ADDR/ID/USER widths must be >= 1");
    end
    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_data
        $error("axi_multicut_cfg: DATA_WIDTH must be a positive multiple of 8");
    end
    if (NUM_CUTS < 0) begin : g_bad_cuts
        $error("axi_multicut_cfg: NUM_CUTS must be >= 0");
    end
    if ($bits(in.aw_addr) != ADDR_WIDTH || $bits(out.aw_addr) != ADDR_WIDTH ||
        $bits(in.w_data) != DATA_WIDTH || $bits(out.w_data) != DATA_WIDTH ||
        $bits(in.aw_id) != ID_WIDTH || $bits(out.aw_id) != ID_WIDTH ||
        $bits(in.aw_user) != USER_WIDTH || $bits(out.aw_user) != USER_WIDTH) begin : g_bad_bus
        $error("axi_multicut_cfg: bundle widths do not match module parameters");
    end
`endif

    logic [AX_WIDTH-1:0] aw_in_pl, aw_out_pl, ar_in_pl, ar_out_pl;
    logic [W_WIDTH-1:0]  w_in_pl, w_out_pl;
    logic [B_WIDTH-1:0]  b_in_pl, b_out_pl;
    logic [R_WIDTH-1:0]  r_in_pl, r_out_pl;
    logic [4:0]          busy_ch;

    assign aw_in_pl = {in.aw_id, in.aw_addr, in.aw_len, in.aw_size, in.aw_burst, in.aw_lock,
                       in.aw_cache, in.aw_prot, in.aw_qos, in.aw_region, in.aw_user};
    assign {out.aw_id, out.aw_addr, out.aw_len, out.aw_size, out.aw_burst, out.aw_lock,
            out.aw_cache, out.aw_prot, out.aw_qos, out.aw_region, out.aw_user} = aw_out_pl;
    assign ar_in_pl = {in.ar_id, in.ar_addr, in.ar_len, in.ar_size, in.ar_burst, in.ar_lock,
                       in.ar_cache, in.ar_prot, in.ar_qos, in.ar_region, in.ar_user};
    assign {out.ar_id, out.ar_addr, out.ar_len, out.ar_size, out.ar_burst, out.ar_lock,
            out.ar_cache, out.ar_prot, out.ar_qos, out.ar_region, out.ar_user} = ar_out_pl;
    assign w_in_pl  = {in.w_data, in.w_strb, in.w_last, in.w_user};
    assign {out.w_data, out.w_strb, out.w_last, out.w_user} = w_out_pl;
    // B and R travel from the master side back to the slave side
    assign b_in_pl  = {out.b_id, out.b_resp, out.b_user};
    assign {in.b_id, in.b_resp, in.b_user} = b_out_pl;
    assign r_in_pl  = {out.r_id, out.r_data, out.r_resp, out.r_last, out.r_user};
    assign {in.r_id, in.r_data, in.r_resp, in.r_last, in.r_user} = r_out_pl;

    axi_multicut_cfg_chan #(.WIDTH(AX_WIDTH), .NUM_CUTS(NUM_CUTS), .BYPASS(BYPASS_MASK[0])) u_aw (
        .clk_i(clk_i), .rst_i(rst_i),
        .valid_i(in.aw_valid), .ready_o(in.aw_ready), .data_i(aw_in_pl),
        .valid_o(out.aw_valid), .ready_i(out.aw_ready), .data_o(aw_out_pl),
        .busy_o(busy_ch[0])
    );

    axi_multicut_cfg_chan #(.WIDTH(W_WIDTH), .NUM_CUTS(NUM_CUTS), .BYPASS(BYPASS_MASK[1])) u_w (
        .clk_i(clk_i), .rst_i(rst_i),
        .valid_i(in.w_valid), .ready_o(in.w_ready), .data_i(w_in_pl),
        .valid_o(out.w_valid), .ready_i(out.w_ready), .data_o(w_out_pl),
        .busy_o(busy_ch[1])
    );

    axi_multicut_cfg_chan #(.WIDTH(B_WIDTH), .NUM_CUTS(NUM_CUTS), .BYPASS(BYPASS_MASK[2])) u_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .valid_i(out.b_valid), .ready_o(out.b_ready), .data_i(b_in_pl),
        .valid_o(in.b_valid), .ready_i(in.b_ready), .data_o(b_out_pl),
        .busy_o(busy_ch[2])
    );

    axi_multicut_cfg_chan #(.WIDTH(AX_WIDTH), .NUM_CUTS(NUM_CUTS), .BYPASS(BYPASS_MASK[3])) u_ar (
        .clk_i(clk_i), .rst_i(rst_i),
        .valid_i(in.ar_valid), .ready_o(in.ar_ready), .data_i(ar_in_pl),
        .valid_o(out.ar_valid), .ready_i(out.ar_ready), .data_o(ar_out_pl),
        .busy_o(busy_ch[3])
    );

    axi_multicut_cfg_chan #(.WIDTH(R_WIDTH), .NUM_CUTS(NUM_CUTS), .BYPASS(BYPASS_MASK[4])) u_r (
        .clk_i(clk_i), .rst_i(rst_i),
        .valid_i(out.r_valid), .ready_o(out.r_ready), .data_i(r_in_pl),
        .valid_o(in.r_valid), .ready_i(in.r_ready), .data_o(r_out_pl),
        .busy_o(busy_ch[4])
    );

    assign busy_o = |busy_ch;
endmodule

// File: tb/tb_axi_multicut_cfg.sv
// Bench for axi_multicut_cfg: two cuts per channel with R bypassed, directed
// latency/capacity/bypass/reset scenarios and a randomized FIFO scoreboard.
module tb_axi_multicut_cfg;
    localparam int         ADDR_W = 32;
    localparam int         DATA_W = 32;
    localparam int         ID_W   = 4;
    localparam int         USER_W = 2;
    localparam int         CUTS   = 2;
    localparam logic [4:0] BYP    = 5'b10000;
    localparam int         AX_W   = ID_W + ADDR_W + 29 + USER_W;
    localparam int         W_W    = DATA_W + DATA_W / 8 + 1 + USER_W;
    localparam int         B_W    = ID_W + 2 + USER_W;
    localparam int         R_W    = ID_W + DATA_W + 3 + USER_W;
    localparam int         N_RAND = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    always #5 clk = ~clk;

    AXI_BUS #(.AXI_ADDR_WIDTH(ADDR_W), .AXI_DATA_WIDTH(DATA_W),
              .AXI_ID_WIDTH(ID_W), .AXI_USER_WIDTH(USER_W)) in_bus ();
    AXI_BUS #(.AXI_ADDR_WIDTH(ADDR_W), .AXI_DATA_WIDTH(DATA_W),
              .AXI_ID_WIDTH(ID_W), .AXI_USER_WIDTH(USER_W)) out_bus ();

    axi_multicut_cfg #(
        .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .ID_WIDTH(ID_W), .USER_WIDTH(USER_W),
        .NUM_CUTS(CUTS), .BYPASS_MASK(BYP)
    ) dut (
        .clk_i(clk), .rst_i(rst), .in(in_bus), .out(out_bus), .busy_o(busy)
    );

    // channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R (same order as the bypass mask)
    logic         src_valid [5];
    logic [127:0] src_data  [5];
    logic         dst_ready [5];
    logic         src_ready [5];
    logic         dst_valid [5];
    logic [127:0] dst_data  [5];

    assign in_bus.aw_valid  = src_valid[0];
    assign src_ready[0]     = in_bus.aw_ready;
    assign {in_bus.aw_id, in_bus.aw_addr, in_bus.aw_len, in_bus.aw_size, in_bus.aw_burst,
            in_bus.aw_lock, in_bus.aw_cache, in_bus.aw_prot, in_bus.aw_qos, in_bus.aw_region,
            in_bus.aw_user} = src_data[0][AX_W-1:0];
    assign dst_valid[0]     = out_bus.aw_valid;
    assign out_bus.aw_ready = dst_ready[0];
    assign dst_data[0] = {{(128-AX_W){1'b0}}, out_bus.aw_id, out_bus.aw_addr, out_bus.aw_len,
                          out_bus.aw_size, out_bus.aw_burst, out_bus.aw_lock, out_bus.aw_cache,
                          out_bus.aw_prot, out_bus.aw_qos, out_bus.aw_region, out_bus.aw_user};

    assign in_bus.w_valid  = src_valid[1];
    assign src_ready[1]    = in_bus.w_ready;
    assign {in_bus.w_data, in_bus.w_strb, in_bus.w_last, in_bus.w_user} = src_data[1][W_W-1:0];
    assign dst_valid[1]    = out_bus.w_valid;
    assign out_bus.w_ready = dst_ready[1];
    assign dst_data[1] = {{(128-W_W){1'b0}}, out_bus.w_data, out_bus.w_strb, out_bus.w_last,
                          out_bus.w_user};

    assign out_bus.b_valid = src_valid[2];
    assign src_ready[2]    = out_bus.b_ready;
    assign {out_bus.b_id, out_bus.b_resp, out_bus.b_user} = src_data[2][B_W-1:0];
    assign dst_valid[2]    = in_bus.b_valid;
    assign in_bus.b_ready  = dst_ready[2];
    assign dst_data[2] = {{(128-B_W){1'b0}}, in_bus.b_id, in_bus.b_resp, in_bus.b_user};

    assign in_bus.ar_valid  = src_valid[3];
    assign src_ready[3]     = in_bus.ar_ready;
    assign {in_bus.ar_id, in_bus.ar_addr, in_bus.ar_len, in_bus.ar_size, in_bus.ar_burst,
            in_bus.ar_lock, in_bus.ar_cache, in_bus.ar_prot, in_bus.ar_qos, in_bus.ar_region,
            in_bus.ar_user} = src_data[3][AX_W-1:0];
    assign dst_valid[3]     = out_bus.ar_valid;
    assign out_bus.ar_ready = dst_ready[3];
    assign dst_data[3] = {{(128-AX_W){1'b0}}, out_bus.ar_id, out_bus.ar_addr, out_bus.ar_len,
                          out_bus.ar_size, out_bus.ar_burst, out_bus.ar_lock, out_bus.ar_cache,
                          out_bus.ar_prot, out_bus.ar_qos, out_bus.ar_region, out_bus.ar_user};

    assign out_bus.r_valid = src_valid[4];
    assign src_ready[4]    = out_bus.r_ready;
    assign {out_bus.r_id, out_bus.r_data, out_bus.r_resp, out_bus.r_last, out_bus.r_user} =
        src_data[4][R_W-1:0];
    assign dst_valid[4]    = in_bus.r_valid;
    assign in_bus.r_ready  = dst_ready[4];
    assign dst_data[4] = {{(128-R_W){1'b0}}, in_bus.r_id, in_bus.r_data, in_bus.r_resp,
                          in_bus.r_last, in_bus.r_user};

    int n_vec = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int chan_w(input int c);
        case (c)
            0, 3:    return AX_W;
            1:       return W_W;
            2:       return B_W;
            default: return R_W;
        endcase
    endfunction

    function automatic logic [127:0] rand_pl(input int c);
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        return v & ((128'(1) << chan_w(c)) - 128'(1));
    endfunction

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // reference model: one in-order FIFO per channel
    logic [127:0] sb_mem [5][256];
    int           sb_wr  [5];
    int           sb_rd  [5];
    logic         hs_prev [5];
    logic         stall  [5];
    logic [127:0] held   [5];

    initial begin
        logic [127:0] p;
        logic [127:0] wexp [64];
        int           lat, wq_wr, wq_rd, nout, nhs, cnt;
        logic         hs;

        for (int c = 0; c < 5; c++) begin
            src_valid[c] = 1'b0;
            src_data[c]  = '0;
            dst_ready[c] = 1'b0;
            sb_wr[c]     = 0;
            sb_rd[c]     = 0;
            hs_prev[c]   = 1'b0;
            stall[c]     = 1'b0;
            held[c]      = '0;
        end

        // reset state on the cut channels
        repeat (2) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            check_value($sformatf("rst_valid_ch%0d", c), 128'(dst_valid[c]), 128'(0));
            check_value($sformatf("rst_ready_ch%0d", c), 128'(src_ready[c]), 128'(1));
        end
        check_value("rst_busy", 128'(busy), 128'(0));
        to_drive();
        rst = 1'b0;

        // single AW beat: latency equals the number of cuts, payload held while stalled
        p = rand_pl(0);
        src_valid[0] = 1'b1;
        src_data[0]  = p;
        @(negedge clk);
        check_value("aw_in_ready", 128'(src_ready[0]), 128'(1));
        to_drive();
        src_valid[0] = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (dst_valid[0] && lat == 0) lat = k;
            check_value("aw_busy", 128'(busy), 128'(1));
        end
        check_value("aw_latency", 128'(lat), 128'(CUTS));
        check_value("aw_payload", dst_data[0], p);
        to_drive();
        dst_ready[0] = 1'b1;
        @(negedge clk);
        to_drive();
        @(negedge clk);
        check_value("aw_drained", 128'(dst_valid[0]), 128'(0));
        check_value("aw_idle_busy", 128'(busy), 128'(0));
        to_drive();
        dst_ready[0] = 1'b0;

        // W capacity with downstream stalled, then in-order release and full-rate streaming
        wq_wr = 0;
        wq_rd = 0;
        src_valid[1] = 1'b1;
        src_data[1]  = rand_pl(1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hs = src_ready[1];
            if (hs) begin
                wexp[wq_wr] = src_data[1];
                wq_wr++;
            end
            to_drive();
            if (hs) src_data[1] = rand_pl(1);
        end
        check_value("w_capacity", 128'(wq_wr), 128'(2 * CUTS));
        check_value("w_ready_full", 128'(src_ready[1]), 128'(0));
        dst_ready[1] = 1'b1;
        nout = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            hs = src_ready[1];
            if (hs) begin
                wexp[wq_wr] = src_data[1];
                wq_wr++;
            end
            if (dst_valid[1]) begin
                nout++;
                check_value("w_order", dst_data[1], wexp[wq_rd]);
                wq_rd++;
            end
            to_drive();
            if (hs) src_data[1] = rand_pl(1);
        end
        check_value("w_throughput", 128'(nout), 128'(12));
        src_valid[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dst_valid[1]) begin
                check_value("w_tail_order", dst_data[1], wexp[wq_rd % 64]);
                wq_rd++;
            end
            to_drive();
        end
        check_value("w_all_delivered", 128'(wq_wr - wq_rd), 128'(0));
        dst_ready[1] = 1'b0;

        // bypassed R: purely combinational in both directions
        p = rand_pl(4);
        src_valid[4] = 1'b1;
        src_data[4]  = p;
        dst_ready[4] = 1'b1;
        #1;
        check_value("r_byp_valid", 128'(dst_valid[4]), 128'(1));
        check_value("r_byp_data", dst_data[4], p);
        check_value("r_byp_ready_hi", 128'(src_ready[4]), 128'(1));
        dst_ready[4] = 1'b0;
        #1;
        check_value("r_byp_ready_lo", 128'(src_ready[4]), 128'(0));
        src_valid[4] = 1'b0;
        #1;
        check_value("r_byp_valid_lo", 128'(dst_valid[4]), 128'(0));
        to_drive();

        // reset in the middle of a stalled AW burst with three beats buffered
        src_valid[0] = 1'b1;
        src_data[0]  = rand_pl(0);
        nhs = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (src_ready[0]) nhs++;
            to_drive();
            src_data[0] = rand_pl(0);
        end
        src_valid[0] = 1'b0;
        check_value("rst_pre_fill", 128'(nhs), 128'(3));
        @(negedge clk);
        check_value("rst_pre_busy", 128'(busy), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            check_value($sformatf("rst_mid_valid_ch%0d", c), 128'(dst_valid[c]), 128'(0));
            check_value($sformatf("rst_mid_ready_ch%0d", c), 128'(src_ready[c]), 128'(1));
        end
        check_value("rst_mid_busy", 128'(busy), 128'(0));
        to_drive();
        rst = 1'b0;
        dst_ready[0] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (dst_valid[0]) cnt++;
            to_drive();
        end
        check_value("rst_flushed", 128'(cnt), 128'(0));
        p = rand_pl(0);
        src_valid[0] = 1'b1;
        src_data[0]  = p;
        @(negedge clk);
        to_drive();
        src_valid[0] = 1'b0;
        lat = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (dst_valid[0] && lat == 0) begin
                lat = k;
                check_value("rst_resume_data", dst_data[0], p);
            end
        end
        check_value("rst_resume_latency", 128'(lat), 128'(CUTS));
        to_drive();

        // randomized traffic on all channels against the FIFO model
        for (int c = 0; c < 5; c++) begin
            src_valid[c] = 1'b0;
            dst_ready[c] = 1'b0;
        end
        for (int cyc = 0; cyc < N_RAND + 30; cyc++) begin
            for (int c = 0; c < 5; c++) begin
                if (!(src_valid[c] && !hs_prev[c])) begin
                    src_valid[c] = (cyc < N_RAND) && ($urandom_range(0, 9) < 6);
                    src_data[c]  = src_valid[c] ? rand_pl(c) : '0;
                end
                dst_ready[c] = (cyc >= N_RAND) || ($urandom_range(0, 9) < 5);
            end
            @(negedge clk);
            for (int c = 0; c < 5; c++) begin
                if (stall[c]) begin
                    check_value($sformatf("stable_valid_ch%0d", c), 128'(dst_valid[c]), 128'(1));
                    check_value($sformatf("stable_data_ch%0d", c), dst_data[c], held[c]);
                end
                hs_prev[c] = src_valid[c] && src_ready[c];
                if (hs_prev[c]) begin
                    sb_mem[c][sb_wr[c] & 255] = src_data[c];
                    sb_wr[c]++;
                end
                if (dst_valid[c] && dst_ready[c]) begin
                    if (sb_wr[c] == sb_rd[c]) begin
                        check_value($sformatf("sb_dup_ch%0d", c), 128'(sb_wr[c] - sb_rd[c]), 128'(1));
                    end else begin
                        check_value($sformatf("sb_ch%0d", c), dst_data[c], sb_mem[c][sb_rd[c] & 255]);
                        sb_rd[c]++;
                    end
                end
                stall[c] = dst_valid[c] && !dst_ready[c];
                held[c]  = dst_data[c];
            end
            to_drive();
        end
        for (int c = 0; c < 5; c++) begin
            check_value($sformatf("sb_empty_ch%0d", c), 128'(sb_wr[c] - sb_rd[c]), 128'(0));
        end
        @(negedge clk);
        check_value("final_busy", 128'(busy), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
